// File: rtl/sprite_oam_scanner.sv
// Per-line OAM scanner: Y-range checks every entry against LY and hands the first
// MAX_SPRITES hits to the X matchers. Define SPRITE_SCAN_EARLY_STOP_EN to end the scan once all slots are full.
module sprite_oam_scanner #(
    parameter int NUM_OAM     = 40,
    parameter int MAX_SPRITES = 10,
    parameter int IDX_W       = 6
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_line_start,
    input  logic [7:0]             i_ly,
    input  logic                   i_obj_tall,
    output logic                   o_oam_rd,
    output logic [IDX_W-1:0]       o_oam_idx,
    input  logic [7:0]             i_oam_y,
    input  logic [7:0]             i_oam_x,
    output logic [MAX_SPRITES-1:0] o_store_slot,
    output logic [7:0]             o_store_x,
    output logic [IDX_W-1:0]       o_store_idx,
    output logic [3:0]             o_store_row,
    output logic [MAX_SPRITES-1:0] o_slot_valid,
    output logic [3:0]             o_sprite_cnt,
    output logic                   o_scan_busy,
    output logic                   o_scan_done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} stateT;

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_OAM - 1);
    localparam logic [3:0]             MAX_CNT  = 4'(MAX_SPRITES);
    localparam logic [MAX_SPRITES-1:0] ONE_SLOT = MAX_SPRITES'(1);

    stateT                  r_state;
    logic [7:0]             r_ly;
    logic                   r_tall;
    logic                   r_cmpValid;
    logic [IDX_W-1:0]       r_cmpIdx;
    logic                   r_oamRd;
    logic [IDX_W-1:0]       r_oamIdx;
    logic [MAX_SPRITES-1:0] r_storeSlot;
    logic [7:0]             r_storeX;
    logic [IDX_W-1:0]       r_storeIdx;
    logic [3:0]             r_storeRow;
    logic [MAX_SPRITES-1:0] r_slotValid;
    logic [3:0]             r_spriteCnt;
    logic                   r_scanBusy;
    logic                   r_scanDone;

    logic [8:0]             w_diff;
    logic [8:0]             w_limit;
    logic                   w_hit;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_stopEarly;
    logic [MAX_SPRITES-1:0] w_slotBit;

    // Entries above the line make the 9-bit difference wrap high, so one compare covers both edges.
    assign w_diff    = {1'b0, r_ly} + 9'd16 - {1'b0, i_oam_y};
    assign w_limit   = r_tall ? 9'd16 : 9'd8;
    assign w_hit     = r_cmpValid && (w_diff < w_limit);
    assign w_full    = (r_spriteCnt == MAX_CNT);
    assign w_accept  = w_hit && !w_full && !i_line_start;
    assign w_slotBit = ONE_SLOT << r_spriteCnt;

`ifdef SPRITE_SCAN_EARLY_STOP_EN
    assign w_stopEarly = w_accept && (r_spriteCnt == MAX_CNT - 4'd1);
`else
    assign w_stopEarly = 1'b0;
`endif

    // A line_start pulse restarts the scan from any state and discards the compare in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_ly        <= '0;
            r_tall      <= 1'b0;
            r_cmpValid  <= 1'b0;
            r_cmpIdx    <= '0;
            r_oamRd     <= 1'b0;
            r_oamIdx    <= '0;
            r_storeSlot <= '0;
            r_storeX    <= '0;
            r_storeIdx  <= '0;
            r_storeRow  <= '0;
            r_slotValid <= '0;
            r_spriteCnt <= '0;
            r_scanBusy  <= 1'b0;
            r_scanDone  <= 1'b0;
        end else begin
            r_storeSlot <= '0;
            r_scanDone  <= 1'b0;
            r_cmpValid  <= r_oamRd;
            r_cmpIdx    <= r_oamIdx;

            if (w_accept) begin
                r_storeSlot <= w_slotBit;
                r_storeX    <= i_oam_x;
                r_storeIdx  <= r_cmpIdx;
                r_storeRow  <= w_diff[3:0];
                r_slotValid <= r_slotValid | w_slotBit;
                r_spriteCnt <= r_spriteCnt + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    r_oamRd <= 1'b0;
                end
                SCAN: begin
                    if ((r_oamIdx == LAST_IDX) || w_stopEarly) begin
                        r_oamRd <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_oamIdx <= r_oamIdx + 1'b1;
                    end
                end
                DRAIN: begin
                    r_state    <= IDLE;
                    r_scanBusy <= 1'b0;
                    r_scanDone <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase

            if (i_line_start) begin
                r_ly        <= i_ly;
                r_tall      <= i_obj_tall;
                r_oamIdx    <= '0;
                r_oamRd     <= 1'b1;
                r_cmpValid  <= 1'b0;
                r_storeSlot <= '0;
                r_slotValid <= '0;
                r_spriteCnt <= '0;
                r_scanBusy  <= 1'b1;
                r_scanDone  <= 1'b0;
                r_state     <= SCAN;
            end
        end
    end

    assign o_oam_rd     = r_oamRd;
    assign o_oam_idx    = r_oamIdx;
    assign o_store_slot = r_storeSlot;
    assign o_store_x    = r_storeX;
    assign o_store_idx  = r_storeIdx;
    assign o_store_row  = r_storeRow;
    assign o_slot_valid = r_slotValid;
    assign o_sprite_cnt = r_spriteCnt;
    assign o_scan_busy  = r_scanBusy;
    assign o_scan_done  = r_scanDone;

endmodule

// File: tb/tb_sprite_oam_scanner.sv
// Directed bench for sprite_oam_scanner with a one-cycle-latency OAM model and a strobe log.
module tb_sprite_oam_scanner;

    localparam int NUM_OAM     = 40;
    localparam int MAX_SPRITES = 10;
    localparam int IDX_W       = 6;

`ifdef SPRITE_SCAN_EARLY_STOP_EN
    localparam int FULL_LATENCY = 13;
    localparam int FULL_READS   = 11;
`else
    localparam int FULL_LATENCY = 42;
    localparam int FULL_READS   = 40;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   lineStart;
    logic [7:0]             ly;
    logic                   objTall;
    logic                   oamRd;
    logic [IDX_W-1:0]       oamIdx;
    logic [7:0]             oamY;
    logic [7:0]             oamX;
    logic [MAX_SPRITES-1:0] storeSlot;
    logic [7:0]             storeX;
    logic [IDX_W-1:0]       storeIdx;
    logic [3:0]             storeRow;
    logic [MAX_SPRITES-1:0] slotValid;
    logic [3:0]             spriteCnt;
    logic                   scanBusy;
    logic                   scanDone;

    logic [7:0] memY [NUM_OAM];
    logic [7:0] memX [NUM_OAM];

    int vectorCount = 0;
    int missCount   = 0;
    int cycleNum    = 0;

    int               qCyc  [$];
    logic [9:0]       qSlot [$];
    logic [7:0]       qX    [$];
    logic [IDX_W-1:0] qIdx  [$];
    logic [3:0]       qRow  [$];
    int   doneCount = 0;
    int   doneCycle = 0;
    logic doneBusy  = 1'b0;
    int   rdCount   = 0;

    int               eCyc  [$];
    logic [9:0]       eSlot [$];
    logic [7:0]       eX    [$];
    logic [IDX_W-1:0] eIdx  [$];
    logic [3:0]       eRow  [$];

    int baseQ, baseDone, baseRd, startCycle;

    sprite_oam_scanner #(
        .NUM_OAM(NUM_OAM), .MAX_SPRITES(MAX_SPRITES), .IDX_W(IDX_W)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_line_start(lineStart), .i_ly(ly),
        .i_obj_tall(objTall), .o_oam_rd(oamRd), .o_oam_idx(oamIdx),
        .i_oam_y(oamY), .i_oam_x(oamX), .o_store_slot(storeSlot),
        .o_store_x(storeX), .o_store_idx(storeIdx), .o_store_row(storeRow),
        .o_slot_valid(slotValid), .o_sprite_cnt(spriteCnt),
        .o_scan_busy(scanBusy), .o_scan_done(scanDone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum++;

    // OAM answers one cycle after each read request.
    always @(posedge clk) begin
        if (oamRd) begin
            oamY <= memY[oamIdx];
            oamX <= memX[oamIdx];
        end
    end

    always @(negedge clk) begin
        if (storeSlot != '0) begin
            qCyc.push_back(cycleNum);
            qSlot.push_back(storeSlot);
            qX.push_back(storeX);
            qIdx.push_back(storeIdx);
            qRow.push_back(storeRow);
        end
        if (scanDone) begin
            doneCount++;
            doneCycle = cycleNum;
            doneBusy  = scanBusy;
        end
        if (oamRd) rdCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] lyIn, input logic tallIn);
        lineStart  = 1'b1;
        ly         = lyIn;
        objTall    = tallIn;
        baseQ      = qCyc.size();
        baseDone   = doneCount;
        baseRd     = rdCount;
        startCycle = cycleNum;
        nextCycle();
        lineStart  = 1'b0;
    endtask

    task automatic fillOam(input logic [7:0] yVal);
        for (int i = 0; i < NUM_OAM; i++) begin
            memY[i] = yVal;
            memX[i] = 8'(100 + i);
        end
    endtask

    task automatic clearExpect();
        eCyc.delete(); eSlot.delete(); eX.delete(); eIdx.delete(); eRow.delete();
    endtask

    task automatic expectStrobe(input logic [9:0] slot, input logic [7:0] x,
                                input logic [IDX_W-1:0] idx, input logic [3:0] row,
                                input int cyc);
        eSlot.push_back(slot);
        eX.push_back(x);
        eIdx.push_back(idx);
        eRow.push_back(row);
        eCyc.push_back(cyc);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (doneCount == baseDone && n < 80) begin
            nextCycle();
            n++;
        end
        checkOutput({tag, ".doneSeen"}, 32'(doneCount - baseDone), 1);
    endtask

    task automatic waitIdx(input string tag, input logic [IDX_W-1:0] target);
        int n = 0;
        while (!(oamRd && oamIdx == target) && n < 60) begin
            nextCycle();
            n++;
        end
        checkOutput({tag, ".reached"}, 32'(oamRd && oamIdx == target), 1);
    endtask

    task automatic checkScan(input string tag, input int expLatency, input int expRd,
                             input logic [3:0] expCnt, input logic [9:0] expValid);
        int n;
        repeat (3) nextCycle();
        checkOutput({tag, ".doneCount"}, 32'(doneCount - baseDone), 1);
        checkOutput({tag, ".latency"}, 32'(doneCycle - startCycle), 32'(expLatency));
        checkOutput({tag, ".busyAtDone"}, 32'(doneBusy), 0);
        checkOutput({tag, ".readCycles"}, 32'(rdCount - baseRd), 32'(expRd));
        checkOutput({tag, ".spriteCnt"}, 32'(spriteCnt), 32'(expCnt));
        checkOutput({tag, ".slotValid"}, 32'(slotValid), 32'(expValid));
        checkOutput({tag, ".strobes"}, 32'(qCyc.size() - baseQ), 32'(eSlot.size()));
        n = (qCyc.size() - baseQ < eSlot.size()) ? qCyc.size() - baseQ : eSlot.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.slot%0d", tag, i), 32'(qSlot[baseQ+i]), 32'(eSlot[i]));
            checkOutput($sformatf("%s.x%0d", tag, i), 32'(qX[baseQ+i]), 32'(eX[i]));
            checkOutput($sformatf("%s.idx%0d", tag, i), 32'(qIdx[baseQ+i]), 32'(eIdx[i]));
            checkOutput($sformatf("%s.row%0d", tag, i), 32'(qRow[baseQ+i]), 32'(eRow[i]));
            checkOutput($sformatf("%s.cyc%0d", tag, i), 32'(qCyc[baseQ+i] - startCycle),
                        32'(eCyc[i]));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".oamRd"}, 32'(oamRd), 0);
        checkOutput({tag, ".oamIdx"}, 32'(oamIdx), 0);
        checkOutput({tag, ".storeSlot"}, 32'(storeSlot), 0);
        checkOutput({tag, ".storeX"}, 32'(storeX), 0);
        checkOutput({tag, ".storeIdx"}, 32'(storeIdx), 0);
        checkOutput({tag, ".storeRow"}, 32'(storeRow), 0);
        checkOutput({tag, ".slotValid"}, 32'(slotValid), 0);
        checkOutput({tag, ".spriteCnt"}, 32'(spriteCnt), 0);
        checkOutput({tag, ".scanBusy"}, 32'(scanBusy), 0);
        checkOutput({tag, ".scanDone"}, 32'(scanDone), 0);
    endtask

    task automatic setupSingle();
        fillOam(8'd0);
        memY[5] = 8'd30;
        memX[5] = 8'd50;
        clearExpect();
        expectStrobe(10'h001, 8'd50, 6'd5, 4'd6, 8);
    endtask

    initial begin
        reset = 1'b1; lineStart = 1'b0; ly = 8'd0; objTall = 1'b0;
        oamY = 8'd0; oamX = 8'd0;
        fillOam(8'd0);
        repeat (3) nextCycle();
        checkAllZero("reset");
        reset = 1'b0;
        nextCycle();

        // Single hit: d = 20+16-30 = 6.
        setupSingle();
        applyStimulus(8'd20, 1'b0);
        checkOutput("single.busyRise", 32'(scanBusy), 1);
        checkOutput("single.firstRd", 32'(oamRd), 1);
        checkOutput("single.firstIdx", 32'(oamIdx), 0);
        waitDone("single");
        checkScan("single", 42, 40, 4'd1, 10'h001);

        // 8-px boundaries: Y=36 d=0, Y=37 wraps, Y=29 d=7, Y=28 d=8.
        fillOam(8'd0);
        memY[0] = 8'd36; memY[1] = 8'd37; memY[2] = 8'd29; memY[3] = 8'd28;
        clearExpect();
        expectStrobe(10'h001, 8'd100, 6'd0, 4'd0, 3);
        expectStrobe(10'h002, 8'd102, 6'd2, 4'd7, 5);
        applyStimulus(8'd20, 1'b0);
        waitDone("short");
        checkScan("short", 42, 40, 4'd2, 10'h003);

        // 16-px boundaries: Y=21 d=15, Y=20 d=16, Y=29 d=7, Y=28 d=8, Y=37 wraps.
        fillOam(8'd0);
        memY[0] = 8'd21; memY[1] = 8'd20; memY[2] = 8'd29; memY[3] = 8'd28; memY[4] = 8'd37;
        clearExpect();
        expectStrobe(10'h001, 8'd100, 6'd0, 4'd15, 3);
        expectStrobe(10'h002, 8'd102, 6'd2, 4'd7, 5);
        expectStrobe(10'h004, 8'd103, 6'd3, 4'd8, 6);
        applyStimulus(8'd20, 1'b0 | 1'b1);
        waitDone("tall");
        checkScan("tall", 42, 40, 4'd3, 10'h007);

        // Every entry hits; X=0 and X=180 entries still take slots.
        fillOam(8'd16);
        clearExpect();
        for (int i = 0; i < NUM_OAM; i++) memX[i] = 8'(i * 20);
        for (int i = 0; i < MAX_SPRITES; i++)
            expectStrobe(10'(1 << i), 8'(i * 20), 6'(i), 4'd0, i + 3);
        applyStimulus(8'd0, 1'b0);
        waitDone("full");
        checkScan("full", FULL_LATENCY, FULL_READS, 4'd10, 10'h3FF);

        // Restart at idx 25 with a hit (idx 24) still in the compare stage.
        fillOam(8'd100);
        memY[1] = 8'd16; memY[3] = 8'd16; memY[5] = 8'd16; memY[7] = 8'd16; memY[24] = 8'd16;
        applyStimulus(8'd0, 1'b0);
        waitIdx("abort", 6'd25);
        checkOutput("abort.cntBefore", 32'(spriteCnt), 4);
        clearExpect();
        expectStrobe(10'h001, 8'd101, 6'd1, 4'd0, 4);
        expectStrobe(10'h002, 8'd103, 6'd3, 4'd0, 6);
        expectStrobe(10'h004, 8'd105, 6'd5, 4'd0, 8);
        expectStrobe(10'h008, 8'd107, 6'd7, 4'd0, 10);
        expectStrobe(10'h010, 8'd124, 6'd24, 4'd0, 27);
        applyStimulus(8'd0, 1'b0);
        checkOutput("abort.noStrobe", 32'(storeSlot), 0);
        checkOutput("abort.cntClear", 32'(spriteCnt), 0);
        checkOutput("abort.validClear", 32'(slotValid), 0);
        checkOutput("abort.restartIdx", 32'(oamIdx), 0);
        waitDone("abort");
        checkScan("abort", 42, 40, 4'd5, 10'h01F);

        // line_start in the DRAIN cycle: first scan's done is suppressed.
        setupSingle();
        applyStimulus(8'd20, 1'b0);
        begin
            int n = 0;
            while (!(scanBusy && !oamRd) && n < 60) begin
                nextCycle();
                n++;
            end
            checkOutput("drain.reached", 32'(scanBusy && !oamRd), 1);
        end
        applyStimulus(8'd20, 1'b0);
        waitDone("drain");
        checkScan("drain", 42, 40, 4'd1, 10'h001);

        // Reset in the middle of a scan, then a clean scan.
        fillOam(8'd16);
        applyStimulus(8'd0, 1'b0);
        waitIdx("midReset", 6'd17);
        reset = 1'b1;
        nextCycle();
        checkAllZero("midReset");
        reset = 1'b0;
        baseDone = doneCount;
        repeat (50) nextCycle();
        checkOutput("midReset.noDone", 32'(doneCount - baseDone), 0);
        setupSingle();
        applyStimulus(8'd20, 1'b0);
        waitDone("afterReset");
        checkScan("afterReset", 42, 40, 4'd1, 10'h001);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
